instruction_prefetch: RTL and testbench

Fetches 32-bit instruction words from InstructionMemory over the shared 256-bit DataBus and buffers them in a small FIFO. Presents them to the Execution unit through a valid/ready handshake. Sits directly upstream of Execution. Fetching stops on the stop instruction (opcode 8'hFF in bits [31:24], e.g. 32'hff000000), and the block stays halted until reset.

---
 rtl/instruction_prefetch.sv | 128 ++++++++++++
 tb/tb_instruction_prefetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch.sv
// instruction_prefetch
// Fetches 32-bit instruction words over the shared bus into a small FIFO and
// presents them to Execution with a valid/ready handshake. A word with opcode
// 8'hFF halts fetching until reset; that stop word is still delivered.
module instruction_prefetch #(
    parameter int          DEPTH      = 4,
    parameter logic [15:0] INSTR_BASE = 16'h1000
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [255:0] DataBus,
    output wire logic [15:0] address,
    output wire logic    nRead,
    output logic         BusReq,
    input  logic         BusGrant,
    output logic [31:0]  InstrData,
    output logic         InstrValid,
    input  logic         InstrReady,
    output logic         Halted,
    output logic [15:0]  PC
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_halted;
    logic [15:0]     r_pc;
    logic [31:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_pending;
    logic            w_space;
    logic            w_space_after;
    logic            w_push;
    logic            w_pop;
    logic            w_own;
    logic            w_stop;
    logic [CW-1:0]   w_count_nxt;
    logic [31:0]     w_word;
    logic            w_unused_bus;

    // Only the low word of the wide shared bus carries instruction data.
    assign w_word       = DataBus[31:0];
    assign w_unused_bus = ^DataBus[255:32];

    // A read in flight occupies a FIFO slot, so it is counted against space.
    assign w_pending     = (r_state == S_CAPTURE);
    assign w_space       = (r_count + CW'(w_pending)) < DEPTH_C;
    assign w_push        = w_pending;
    assign w_pop         = InstrValid && InstrReady;
    assign w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
    assign w_space_after = w_count_nxt < DEPTH_C;
    assign w_stop        = (w_word[31:24] == 8'hFF);

    // Bus is held from the request through CAPTURE; no request while in reset.
    assign BusReq = !Reset &&
                    ((r_state == S_IDLE && !r_halted && w_space) ||
                     r_state == S_ISSUE || r_state == S_CAPTURE);

    // Bus pins are driven only while granted and mid-transaction.
    assign w_own   = BusGrant && (r_state == S_ISSUE || r_state == S_CAPTURE);
    assign address = w_own ? r_pc : 16'hzzzz;
    assign nRead   = w_own ? (r_state != S_ISSUE) : 1'bz;

    assign InstrValid = (r_count != '0);
    assign InstrData  = InstrValid ? r_mem[r_rd_ptr] : 32'h0;
    assign Halted     = r_halted;
    assign PC         = r_pc;

    // Fetch FSM, PC, halt flag and FIFO pointers/occupancy.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_halted <= 1'b0;
            r_pc     <= INSTR_BASE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (BusReq && BusGrant) r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    // Without the grant no read went out; retry the same PC later.
                    r_state <= BusGrant ? S_CAPTURE : S_IDLE;
                end
                S_CAPTURE: begin
                    // The read was already issued, so capture completes even without grant.
                    r_pc <= r_pc + 16'd1;
                    if (w_stop) begin
                        r_halted <= 1'b1;
                        r_state  <= S_IDLE;
                    end else if (w_space_after && BusGrant) begin
                        r_state <= S_ISSUE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
        end
    end

    // FIFO storage; occupancy is reset, the data array need not be.
    always_ff @(posedge Clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_word;
    end

    // The space rule must make a push into a full FIFO impossible.
    always_ff @(posedge Clk) begin
        if (!Reset) assert (!(w_push && !w_pop && r_count == DEPTH_C));
    end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: bus-side memory responder plus a scoreboard
// of expected words, with directed scenarios driven from one initial block.
module tb_instruction_prefetch;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [255:0] DataBus;
    wire  [15:0]  address;
    wire          nRead;
    logic         BusReq;
    logic         BusGrant;
    logic [31:0]  InstrData;
    logic         InstrValid;
    logic         InstrReady;
    logic         Halted;
    logic [15:0]  PC;

    logic         w_rst;
    wire  [15:0]  w_address;
    wire          w_nread;
    logic         w_busreq;
    logic [31:0]  w_data;
    logic         w_valid;
    logic         w_halted;
    logic [15:0]  w_pc;

    int           errors = 0;
    int           checks = 0;
    int           reads = 0;
    int           delivered = 0;
    logic [31:0]  sb[$];
    logic [15:0]  rd_addrs[$];
    logic [15:0]  exp_pc = 16'h1000;
    bit           basic = 1'b1;

    instruction_prefetch #(.DEPTH(4), .INSTR_BASE(16'h1000)) dut (
        .Clk(Clk), .Reset(Reset), .DataBus(DataBus), .address(address),
        .nRead(nRead), .BusReq(BusReq), .BusGrant(BusGrant),
        .InstrData(InstrData), .InstrValid(InstrValid), .InstrReady(InstrReady),
        .Halted(Halted), .PC(PC)
    );

    instruction_prefetch #(.DEPTH(4), .INSTR_BASE(16'hFFFF)) dut_wrap (
        .Clk(Clk), .Reset(w_rst), .DataBus(256'h0), .address(w_address),
        .nRead(w_nread), .BusReq(w_busreq), .BusGrant(1'b1),
        .InstrData(w_data), .InstrValid(w_valid), .InstrReady(1'b1),
        .Halted(w_halted), .PC(w_pc)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (basic && a == 16'h1000) return 32'h01000102;
        if (basic && a == 16'h1001) return 32'h02030405;
        if (basic && a == 16'h1002) return 32'hff000000;
        return {8'h40, 8'h00, a};
    endfunction

    // Memory responder and scoreboard, sampled mid-cycle.
    always @(negedge Clk) begin
        logic [31:0] exp_w;
        if (BusGrant === 1'b0) begin
            checks++;
            assert (address === 16'hzzzz) else begin
                errors++; $error("FAIL bus_addr_z: address=%h required=zzzz", address);
            end
            checks++;
            assert (nRead === 1'bz) else begin
                errors++; $error("FAIL bus_nread_z: nRead=%b required=z", nRead);
            end
        end
        if (nRead !== 1'bz && nRead === 1'b0) begin
            checks++;
            assert (address === exp_pc) else begin
                errors++; $error("FAIL read_addr: address=%h required=%h", address, exp_pc);
            end
            rd_addrs.push_back(address);
            reads++;
            DataBus = {224'h0, mem_word(address)};
            sb.push_back(mem_word(address));
            exp_pc = exp_pc + 16'd1;
        end
        if (InstrValid === 1'b1 && InstrReady === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                assert (sb.size() != 0) else begin
                    errors++; $error("FAIL sb_underflow: delivered=%h required=none", InstrData);
                end
            end else begin
                exp_w = sb.pop_front();
                assert (InstrData === exp_w) else begin
                    errors++; $error("FAIL deliver: InstrData=%h required=%h", InstrData, exp_w);
                end
                delivered++;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++; $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic flush();
        sb.delete();
        rd_addrs.delete();
        reads = 0;
        delivered = 0;
        exp_pc = 16'h1000;
    endtask

    task automatic wait_reads(input int n, input string tag);
        int k = 0;
        while (reads < n && k < 40) begin
            tick();
            k++;
        end
        checks++;
        assert (reads >= n) else begin
            errors++; $error("FAIL %s: reads=%0d required=%0d", tag, reads, n);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; BusGrant = 1'b1; InstrReady = 1'b1; DataBus = '0; w_rst = 1'b1;
        tick(2);

        // Reset state
        check32("rst_valid", {31'b0, InstrValid}, 32'd0);
        check32("rst_data", InstrData, 32'h0);
        check32("rst_halted", {31'b0, Halted}, 32'd0);
        check32("rst_busreq", {31'b0, BusReq}, 32'd0);
        check32("rst_pc", {16'b0, PC}, 32'h1000);
        checks++;
        assert (address === 16'hzzzz) else begin
            errors++; $error("FAIL rst_addr_z: address=%h required=zzzz", address);
        end

        // Basic fetch and first-valid latency
        flush();
        Reset = 1'b0;
        #1;
        check32("c0_busreq", {31'b0, BusReq}, 32'd1);
        tick();
        check32("c1_addr", {16'b0, address}, 32'h1000);
        check32("c1_nread", {31'b0, nRead}, 32'd0);
        tick();
        check32("c2_nread", {31'b0, nRead}, 32'd1);
        check32("c2_valid", {31'b0, InstrValid}, 32'd0);
        tick();
        check32("c3_valid", {31'b0, InstrValid}, 32'd1);
        check32("c3_data", InstrData, 32'h01000102);
        tick(8);
        check32("basic_halted", {31'b0, Halted}, 32'd1);
        check32("basic_busreq", {31'b0, BusReq}, 32'd0);
        check32("basic_pc", {16'b0, PC}, 32'h1003);
        check32("basic_reads", reads, 32'd3);
        check32("basic_delivered", delivered, 32'd3);
        check32("basic_addr2", {16'b0, rd_addrs[2]}, 32'h1002);

        // Backpressure
        basic = 1'b0; InstrReady = 1'b0; Reset = 1'b1;
        tick();
        flush();
        check32("bp_halt_clear", {31'b0, Halted}, 32'd0);
        Reset = 1'b0;
        tick(20);
        check32("bp_reads", reads, 32'd4);
        check32("bp_busreq", {31'b0, BusReq}, 32'd0);
        check32("bp_head", InstrData, 32'h40001000);
        InstrReady = 1'b1;
        tick(30);
        check32("bp_drained", {31'b0, delivered >= 4}, 32'd1);

        // Grant withdrawal in ISSUE, then in CAPTURE
        Reset = 1'b1;
        tick();
        flush();
        Reset = 1'b0;
        tick();
        BusGrant = 1'b0;
        tick();
        check32("gi_pc", {16'b0, PC}, 32'h1000);
        check32("gi_busreq", {31'b0, BusReq}, 32'd1);
        tick(2);
        check32("gi_reads", reads, 32'd0);
        BusGrant = 1'b1;
        tick(2);
        check32("gc_reissue", {16'b0, rd_addrs[0]}, 32'h1000);
        BusGrant = 1'b0;
        tick();
        check32("gc_pc", {16'b0, PC}, 32'h1001);
        check32("gc_valid", {31'b0, InstrValid}, 32'd1);
        check32("gc_data", InstrData, 32'h40001000);
        BusGrant = 1'b1;
        tick(10);
        check32("gc_resume", {31'b0, delivered >= 3}, 32'd1);

        // Simultaneous push and pop with three buffered and one pending
        InstrReady = 1'b0; Reset = 1'b1;
        tick();
        flush();
        Reset = 1'b0;
        wait_reads(4, "pp_fill");
        check32("pp_valid", {31'b0, InstrValid}, 32'd1);
        InstrReady = 1'b1;
        tick();
        check32("pp_busreq", {31'b0, BusReq}, 32'd1);
        check32("pp_head", InstrData, 32'h40001001);
        tick(30);
        check32("pp_order", {31'b0, delivered >= 5}, 32'd1);

        // Reset during CAPTURE with two entries buffered
        InstrReady = 1'b0; Reset = 1'b1;
        tick();
        flush();
        Reset = 1'b0;
        wait_reads(3, "rm_fill");
        check32("rm_pre_valid", {31'b0, InstrValid}, 32'd1);
        Reset = 1'b1;
        tick();
        check32("rm_valid", {31'b0, InstrValid}, 32'd0);
        check32("rm_data", InstrData, 32'h0);
        check32("rm_pc", {16'b0, PC}, 32'h1000);
        check32("rm_halted", {31'b0, Halted}, 32'd0);
        checks++;
        assert (address === 16'hzzzz) else begin
            errors++; $error("FAIL rm_addr_z: address=%h required=zzzz", address);
        end
        checks++;
        assert (nRead === 1'bz) else begin
            errors++; $error("FAIL rm_nread_z: nRead=%b required=z", nRead);
        end
        flush();
        Reset = 1'b0; InstrReady = 1'b1;
        tick(4);
        check32("rm_restart", {16'b0, rd_addrs[0]}, 32'h1000);

        // PC wrap from 16'hFFFF
        w_rst = 1'b0;
        tick();
        check32("wrap_addr0", {16'b0, w_address}, 32'h0000FFFF);
        check32("wrap_nread0", {31'b0, w_nread}, 32'd0);
        tick(2);
        check32("wrap_addr1", {16'b0, w_address}, 32'h00000000);
        check32("wrap_pc", {16'b0, w_pc}, 32'h00000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
